// File: rtl/mem_access_unit.sv
// Load/store unit: one req/ack memory access per instruction, with lane steering,
// load extension, alignment/legality checks and a bounded wait for the memory ack.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic        iWrite,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oError,
  output logic [31:0] oRData,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [3:0]  oMemByteEn,
  output logic [31:0] oMemWData,
  input  logic        iMemAck,
  input  logic [31:0] iMemRData
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               write_q;
  logic [2:0]         funct3_q;
  logic [31:0]        addr_q;
  logic [3:0]         be_q;
  logic [31:0]        wdata_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        rdata_q;
  logic               legal_s;
  logic               expire_s;

  // funct3[1:0] encodes the access size for both loads and stores: 00 byte, 01 half, 10 word
  function automatic logic access_ok(input logic wr, input logic [2:0] f3, input logic [1:0] a);
    logic legal;
    logic misaligned;
    if (wr) legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
    else    legal = (f3[1:0] != 2'b11) && (f3 != 3'b110);
    misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return legal && !misaligned;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_data(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = rd[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  assign legal_s  = access_ok(iWrite, iFunct3, iAddr[1:0]);
  assign expire_s = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (iStart) state_d = legal_s ? REQ : DONE;
      REQ:     if (iMemAck || expire_s) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access latch, wait counter and load result; an ack on the expiring cycle still wins
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= 32'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (iStart) begin
            write_q  <= iWrite;
            funct3_q <= iFunct3;
            addr_q   <= iAddr;
            be_q     <= byte_en(iFunct3, iAddr[1:0]);
            wdata_q  <= store_data(iFunct3, iWData);
            err_q    <= !legal_s;
            cnt_q    <= '0;
          end
        end
        REQ: begin
          if (iMemAck) begin
            if (!write_q) rdata_q <= load_data(funct3_q, addr_q[1:0], iMemRData);
          end else if (expire_s) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    oBusy      = ((state_q == IDLE) && iStart) || (state_q == REQ);
    oMemReq    = (state_q == REQ);
    oMemWe     = (state_q == REQ) && write_q;
    oDone      = (state_q == DONE);
    oError     = (state_q == DONE) && err_q;
    oMemAddr   = {addr_q[31:2], 2'b00};
    oMemByteEn = be_q;
    oMemWData  = wdata_q;
    oRData     = rdata_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver queues expected memory requests and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_access_unit;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        iRST, iStart, iWrite, iMemAck;
  logic [2:0]  iFunct3;
  logic [31:0] iAddr, iWData, iMemRData;
  logic        oBusy, oDone, oError, oMemReq, oMemWe;
  logic [31:0] oRData, oMemAddr, oMemWData;
  logic [3:0]  oMemByteEn;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          cyc;
    int          len;
    string       name;
  } req_t;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          cyc;
    string       name;
  } done_t;

  req_t  rq[$];
  done_t dq[$];

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .iCLK(clk), .iRST(iRST), .iStart(iStart), .iWrite(iWrite), .iFunct3(iFunct3),
    .iAddr(iAddr), .iWData(iWData), .oBusy(oBusy), .oDone(oDone), .oError(oError),
    .oRData(oRData), .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
    .oMemByteEn(oMemByteEn), .oMemWData(oMemWData), .iMemAck(iMemAck),
    .iMemRData(iMemRData)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: compares memory requests and completions against the queued expectations
  initial begin
    req_t  cur;
    done_t d;
    bit    have = 1'b0;
    bit    prev_req = 1'b0;
    bit    unstable = 1'b0;
    int    req_len = 0;
    forever begin
      @(negedge clk);
      if (oMemReq && !prev_req) begin
        req_len  = 1;
        unstable = 1'b0;
        if (rq.size() == 0) begin
          have = 1'b0;
          check("unexpected memreq", 32'(oMemReq), 32'd0);
        end else begin
          cur  = rq.pop_front();
          have = 1'b1;
          check({cur.name, " we"}, 32'(oMemWe), 32'(cur.we));
          check({cur.name, " addr"}, oMemAddr, cur.addr);
          check({cur.name, " byteen"}, 32'(oMemByteEn), 32'(cur.be));
          check({cur.name, " wdata"}, oMemWData, cur.wd);
          check({cur.name, " req cycle"}, 32'(cyc), 32'(cur.cyc));
        end
      end else if (oMemReq) begin
        req_len++;
        if (have && ({oMemWe, oMemAddr, oMemByteEn, oMemWData} !==
                     {cur.we, cur.addr, cur.be, cur.wd})) unstable = 1'b1;
      end else if (prev_req && have) begin
        check({cur.name, " req length"}, 32'(req_len), 32'(cur.len));
        check({cur.name, " req stable"}, 32'(unstable), 32'd0);
        have = 1'b0;
      end
      prev_req = oMemReq;

      if (oDone) begin
        if (dq.size() == 0) begin
          check("unexpected done", 32'(oDone), 32'd0);
        end else begin
          d = dq.pop_front();
          check({d.name, " done cycle"}, 32'(cyc), 32'(d.cyc));
          check({d.name, " error"}, 32'(oError), 32'(d.err));
          check({d.name, " rdata"}, oRData, d.rd);
        end
      end else if (oError) begin
        check("error without done", 32'(oError), 32'd0);
      end
    end
  end

  // ack_c: -1 rejected up front (no request), 0 never acked (timeout), k>0 ack in cycle k
  task automatic access(input string nm, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int ack_c,
                        input logic [31:0] mrd, input logic [3:0] be, input logic [31:0] ewd,
                        input logic [31:0] erd, input bit poke);
    int    c0;
    int    lat;
    req_t  r;
    done_t d;
    @(posedge clk); #1;
    iStart = 1'b1; iWrite = wr; iFunct3 = f3; iAddr = addr; iWData = wd; iMemAck = 1'b0;
    c0  = cyc;
    lat = (ack_c < 0) ? 1 : (ack_c == 0) ? TO + 1 : ack_c + 1;
    if (ack_c >= 0) begin
      r.we = wr; r.addr = {addr[31:2], 2'b00}; r.be = be; r.wd = ewd;
      r.cyc = c0 + 1; r.len = (ack_c == 0) ? TO : ack_c; r.name = nm;
      rq.push_back(r);
    end
    d.err = (ack_c <= 0); d.rd = erd; d.cyc = c0 + lat; d.name = nm;
    dq.push_back(d);
    #1 check({nm, " busy start"}, 32'(oBusy), 32'd1);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      iStart    = 1'b0;
      iMemAck   = (c == ack_c);
      iMemRData = (c == ack_c) ? mrd : 32'h55AA_55AA;
      if (c == lat && poke) begin
        iStart = 1'b1; iWrite = 1'b0; iFunct3 = 3'b010; iAddr = 32'h100;
      end
      #1 check({nm, " busy"}, 32'(oBusy), (c < lat) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    iRST = 1'b1; iStart = 1'b0; iWrite = 1'b0; iFunct3 = 3'd0; iAddr = 32'd0;
    iWData = 32'd0; iMemAck = 1'b0; iMemRData = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(oBusy), 32'd0);
    check("reset memreq/we", {30'd0, oMemReq, oMemWe}, 32'd0);
    check("reset done/error", {30'd0, oDone, oError}, 32'd0);
    check("reset byteen", 32'(oMemByteEn), 32'd0);
    check("reset memaddr", oMemAddr, 32'd0);
    check("reset memwdata", oMemWData, 32'd0);
    check("reset rdata", oRData, 32'd0);
    @(posedge clk); #1 iRST = 1'b0;

    //      name      wr    f3      addr          wdata          ack  mem rdata      be       exp wdata      exp rdata    poke
    access("LW",      1'b0, 3'b010, 32'h0000_0010, 32'h0,         1,  32'hDEAD_BEEF, 4'b1111, 32'h0,         32'hDEAD_BEEF, 1'b0);
    access("LB",      1'b0, 3'b000, 32'h0000_0013, 32'h0,         1,  32'h80FF_1234, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0);
    access("LBU",     1'b0, 3'b100, 32'h0000_0013, 32'h0,         1,  32'h80FF_1234, 4'b1000, 32'h0,         32'h0000_0080, 1'b0);
    access("SH",      1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 5,  32'h0,         4'b1100, 32'hABCD_ABCD, 32'h0000_0080, 1'b1);
    access("LW mis",  1'b0, 3'b010, 32'h0000_0006, 32'h0,         -1, 32'h0,         4'b0000, 32'h0,         32'h0000_0080, 1'b0);
    access("L f3=3",  1'b0, 3'b011, 32'h0000_0000, 32'h0,         -1, 32'h0,         4'b0000, 32'h0,         32'h0000_0080, 1'b0);
    access("LH mis",  1'b0, 3'b001, 32'h0000_0011, 32'h0,         -1, 32'h0,         4'b0000, 32'h0,         32'h0000_0080, 1'b0);
    access("S f3=4",  1'b1, 3'b100, 32'h0000_0030, 32'h1111_2222, -1, 32'h0,         4'b0000, 32'h0,         32'h0000_0080, 1'b0);
    access("LH hi",   1'b0, 3'b001, 32'h0000_0012, 32'h0,         2,  32'h80FF_1234, 4'b1100, 32'h0,         32'hFFFF_80FF, 1'b0);
    access("LHU hi",  1'b0, 3'b101, 32'h0000_0012, 32'h0,         1,  32'h80FF_1234, 4'b1100, 32'h0,         32'h0000_80FF, 1'b0);
    access("LB pos",  1'b0, 3'b000, 32'h0000_0011, 32'h0,         1,  32'h0000_7F00, 4'b0010, 32'h0,         32'h0000_007F, 1'b0);
    access("LH lo",   1'b0, 3'b001, 32'h0000_0010, 32'h0,         1,  32'h1234_8765, 4'b0011, 32'h0,         32'hFFFF_8765, 1'b0);
    access("SB",      1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 1,  32'h0,         4'b0010, 32'hA5A5_A5A5, 32'hFFFF_8765, 1'b0);
    access("SW",      1'b1, 3'b010, 32'h0000_0004, 32'hCAFE_F00D, 3,  32'h0,         4'b1111, 32'hCAFE_F00D, 32'hFFFF_8765, 1'b0);
    access("LW tmo",  1'b0, 3'b010, 32'h0000_0040, 32'h0,         0,  32'h0,         4'b1111, 32'h0,         32'hFFFF_8765, 1'b0);
    access("LW edge", 1'b0, 3'b010, 32'h0000_0044, 32'h0,         TO, 32'h0BAD_F00D, 4'b1111, 32'h0,         32'h0BAD_F00D, 1'b0);

    // Reset during the third REQ cycle: request drops, no completion, state back to IDLE
    begin
      req_t r;
      @(posedge clk); #1;
      iStart = 1'b1; iWrite = 1'b0; iFunct3 = 3'b010; iAddr = 32'h48; iWData = 32'h0;
      r.we = 1'b0; r.addr = 32'h48; r.be = 4'b1111; r.wd = 32'h0;
      r.cyc = cyc + 1; r.len = 3; r.name = "LW rst";
      rq.push_back(r);
      for (int c = 1; c <= 3; c++) begin
        @(posedge clk); #1;
        iStart = 1'b0; iMemAck = 1'b0;
        if (c == 3) iRST = 1'b1;
      end
      @(posedge clk); #1;
      iRST = 1'b0;
      check("rst memreq", 32'(oMemReq), 32'd0);
      check("rst done", 32'(oDone), 32'd0);
      check("rst busy", 32'(oBusy), 32'd0);
      check("rst rdata", oRData, 32'd0);
    end

    access("LW after", 1'b0, 3'b010, 32'h0000_004C, 32'h0,        1,  32'h1357_9BDF, 4'b1111, 32'h0,         32'h1357_9BDF, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("pending requests", 32'(rq.size()), 32'd0);
    check("pending completions", 32'(dq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
